pairing_result_uart_tx: RTL

Downstream readout stage for BN254_pairing. It walks a range of extout_addr addresses and captures each 304-bit extout_data word. Each word is serialised as 38 bytes on a UART 8N1 line. This replaces the ad-hoc shift-register dump with a framed, host-readable byte stream.

---
 rtl/pairing_result_uart_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pairing_result_uart_tx.sv
// Readout stage for BN254_pairing results: walks a range of extout_addr
// addresses, captures each DATA_W-bit word and sends it LSB byte first
// as a stream of UART 8N1 frames on uart_txd.
module pairing_result_uart_tx #(
  parameter int DATA_W       = 304,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] extout_addr,
  input  logic [DATA_W-1:0] extout_data,
  output logic              uart_txd
);

  localparam int BYTES  = DATA_W / 8;
  localparam int TMR_W  = $clog2(CLKS_PER_BIT);
  localparam int RD_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_LAT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ONE_WORD  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [2:0]          bit_q, bit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic: sequencing of reads, frame bits and word stepping.
  // The line level is derived from the next state so uart_txd is a clean
  // register output that changes exactly on state boundaries.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // The done cycle still counts as busy for start arbitration.
        if (start && !done_q) begin
          if (num_words != '0) begin
            addr_d  = base_addr;
            left_d  = num_words;
            rd_d    = RD_LAST;
            busy_d  = 1'b1;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_q == '0) begin
          state_d = LOAD;
        end else begin
          rd_d = rd_q - RD_W'(1);
        end
      end
      LOAD: begin
        shift_d = extout_data;
        byte_d  = '0;
        tmr_d   = TMR_LAST;
        state_d = START_BIT;
      end
      START_BIT: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_LAST;
          bit_d   = 3'd0;
          state_d = DATA_BITS;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DATA_BITS: begin
        if (tmr_q == '0) begin
          tmr_d = TMR_LAST;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      STOP_BIT: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_LAST;
          shift_d = shift_q >> 8;
          if (byte_q == BYTE_LAST) begin
            state_d = NEXT;
            // Last word: done and busy-drop coincide with the NEXT cycle.
            if (left_q == ONE_WORD) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = START_BIT;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      NEXT: begin
        left_d = left_q - ONE_WORD;
        if (left_q != ONE_WORD) begin
          addr_d  = addr_q + ONE_WORD;
          rd_d    = RD_LAST;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START_BIT: txd_d = 1'b0;
      DATA_BITS: txd_d = shift_d[bit_d];
      default:   txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      rd_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign extout_addr = addr_q;
  assign uart_txd    = txd_q;

endmodule
